td4_prog_loader: RTL and testbench
==================================

# td4_prog_loader

Program loader for the TD4 core: accepts a framed byte stream over a valid/ready handshake and writes the 16 x 8 instruction memory. It holds the core in reset while loading and releases it only after the checksum verifies. It sits between a host byte source (serial front end, switch bank, or testbench) and the write port of the instruction RAM that the core's instruction pointer reads.

## Interface
Parameters:
- DEPTH, 16, number of program bytes per frame; equals instruction memory depth
- ADDR_W, 4, memory address width, log2(DEPTH)
- HEADER, 8'hA5, frame start byte

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins, or restarts, a load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per byte
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- cpu_reset_n  out  1  active-low reset to the TD4 core; high only in RUN
- done  out  1  level; frame loaded and verified
- error  out  1  level; checksum mismatch
- byte_count  out  ADDR_W+1  program bytes written in the current frame, 0..DEPTH

## Operation
- Frame format: HEADER, then DEPTH program bytes for addresses 0..DEPTH-1 in order, then one checksum byte C. The frame is valid when (sum of program bytes + C) mod 256 == 8'h00.
- A handshake occurs when in_valid && in_ready.
- States:
  - IDLE: in_ready=0. start -> SYNC.
  - SYNC: in_ready=1. A handshake with HEADER -> LOAD, with addr=0, sum=0, byte_count=0. Any other byte is discarded and the state stays in SYNC.
  - LOAD: in_ready=1. Each handshake writes the byte to the current addr, adds it to the 8-bit sum (wraps mod 256), increments addr and byte_count. After the handshake that gives byte_count=DEPTH -> CHECK. HEADER values inside LOAD are data, not resync.
  - CHECK: in_ready=1. On handshake, (sum + in_data) mod 256 == 0 -> RUN; otherwise -> ERROR.
  - RUN: in_ready=0, done=1, cpu_reset_n=1. start -> SYNC.
  - ERROR: in_ready=0, error=1, cpu_reset_n=0. start -> SYNC.
- start in SYNC, LOAD or CHECK restarts: go to SYNC, clear sum and byte_count, and discard any byte offered that cycle. start has priority over a simultaneous handshake.
- Entering SYNC from RUN drops cpu_reset_n and done on the next edge.
- addr is ADDR_W bits and wraps to 0 after DEPTH-1. CHECK is entered by byte_count, not by the address wrap.
- Memory contents are never cleared. After a restart, an error or a reset, partially written contents remain until overwritten.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, done=0, error=0, byte_count=0.
- A reset asserted mid-frame returns all of the above on the next edge; no write is issued in that cycle.
- in_ready reflects the current state. A combinational dependency on in_valid is forbidden.
- Write latency: a data handshake in cycle N gives mem_we=1 with that addr/data in cycle N+1, and byte_count is incremented in N+1. Back-to-back handshakes give back-to-back writes at full rate.
- Checksum handshake in cycle N: done or error, and cpu_reset_n, update in cycle N+1.
- Minimum frame time from the start pulse to done is 1 + 1 + DEPTH + 1 cycles with in_valid held high.

## Structure
- Shared package td4_pkg holds:
  - state enum (IDLE, SYNC, LOAD, CHECK, RUN, ERROR)
  - PROG_DEPTH=16, PROG_ADDR_W=4, FRAME_HEADER=8'hA5
- No sub-module. The FSM, address/count register and checksum accumulator fit in one module of roughly 150–250 lines.
- The TD4 top level instantiates this block and drives its instruction RAM write port from mem_we/mem_addr/mem_wdata.

## Test plan
- Good frame: start, A5, the 16 bytes B7 01 E1 01 E3 B6 01 E6 01 E8 B0 B4 01 EA B8 FF, checksum = two's complement of their sum. Expect 16 mem_we pulses at addr 0..15 with matching data, byte_count=16, done=1 and cpu_reset_n=1 one cycle after the checksum handshake.
- Bad checksum: same frame with checksum+1. Expect error=1, done=0, cpu_reset_n stays 0. A following start and a correct frame then give done=1, error=0.
- Resync: start, then 00 FF 5A A5 followed by a valid frame body. Expect no mem_we for the first three bytes, the first write at addr 0, and done=1.
- Backpressure and gaps: in_valid randomly deasserted during LOAD. Expect exactly 16 writes in address order, no duplicates, done=1. Also verify in_ready=0 in IDLE, RUN and ERROR, with no writes when in_valid=1 there.
- Restart mid-load: start pulse after 7 data bytes, coincident with an 8th byte offered. Expect the 8th byte to be dropped, the state to return to SYNC with byte_count=0, and a new full frame to write from addr 0 and reach done.
- Reset mid-load: reset after 5 data bytes. Expect all outputs at their reset values next cycle and no further writes; addresses 0..4 keep their new data.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg
// Shared definitions for the TD4 program loader: loader state encoding,
// program memory geometry and the frame start byte.
// No ports; imported by td4_prog_loader.

package td4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_e;

    localparam int         PROG_DEPTH   = 16;
    localparam int         PROG_ADDR_W  = 4;
    localparam logic [7:0] FRAME_HEADER = 8'hA5;

endpackage

// File: rtl/td4_prog_loader.sv
// td4_prog_loader
// Receives a framed byte stream (header, DEPTH program bytes, checksum) over
// a valid/ready handshake, writes the program bytes into the TD4 instruction
// memory and holds the core in reset until the checksum has verified.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        one-cycle pulse that begins or restarts a load
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle (registered, state only)
//   mem_we       instruction memory write strobe, one cycle per byte
//   mem_addr     instruction memory write address
//   mem_wdata    instruction memory write data
//   cpu_reset_n  active-low reset to the core, high only in RUN
//   done         frame loaded and checksum verified
//   error        checksum mismatch
//   byte_count   program bytes written in the current frame, 0..DEPTH

module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int         DEPTH  = PROG_DEPTH,
    parameter int         ADDR_W = PROG_ADDR_W,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int                 COUNT_W    = ADDR_W + 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DEPTH - 1);

    state_e state_q, state_d;

    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_n_q, cpu_reset_n_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [COUNT_W-1:0] byte_count_q, byte_count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;

    logic       handshake;
    logic [7:0] sum_plus_in;

    // in_ready_q already reflects the current state, so the handshake needs
    // no combinational path from in_valid back to in_ready.
    assign handshake   = in_valid && in_ready_q;
    assign sum_plus_in = sum_q + in_data;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start wins over any byte offered in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SYNC;
            end
            SYNC: begin
                if (start) begin
                    state_d = SYNC;
                end else if (handshake && in_data == HEADER) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Leaving LOAD is driven by the byte count, not the address
                // wrap, so a header value inside the body is just data.
                if (start) begin
                    state_d = SYNC;
                end else if (handshake && byte_count_q == LAST_COUNT) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (start) begin
                    state_d = SYNC;
                end else if (handshake) begin
                    state_d = (sum_plus_in == 8'h00) ? RUN : ERROR;
                end
            end
            RUN, ERROR: begin
                if (start) state_d = SYNC;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Status outputs are computed from the next state so that
    // the registered copies line up with the state register.
    always_comb begin
        in_ready_d    = (state_d == SYNC) || (state_d == LOAD) || (state_d == CHECK);
        done_d        = (state_d == RUN);
        error_d       = (state_d == ERROR);
        cpu_reset_n_d = (state_d == RUN);
    end

    // Write port, address counter, byte counter and checksum accumulator.
    // Write address/data hold their last value between strobes.
    always_comb begin
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        addr_d       = addr_q;
        sum_d        = sum_q;
        byte_count_d = byte_count_q;
        if (start) begin
            addr_d       = '0;
            sum_d        = 8'h00;
            byte_count_d = '0;
        end else if (handshake) begin
            case (state_q)
                SYNC: begin
                    if (in_data == HEADER) begin
                        addr_d       = '0;
                        sum_d        = 8'h00;
                        byte_count_d = '0;
                    end
                end
                LOAD: begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_wdata_d  = in_data;
                    addr_d       = addr_q + ADDR_W'(1);
                    sum_d        = sum_plus_in;
                    byte_count_d = byte_count_q + COUNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 8'h00;
            cpu_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            byte_count_q  <= '0;
            addr_q        <= '0;
            sum_q         <= 8'h00;
        end else begin
            in_ready_q    <= in_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            done_q        <= done_d;
            error_q       <= error_d;
            byte_count_q  <= byte_count_d;
            addr_q        <= addr_d;
            sum_q         <= sum_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign done        = done_q;
    assign error       = error_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb_td4_prog_loader
// Directed bench for td4_prog_loader: good frame from a vector table, bad
// checksum, resync, backpressure, restart mid-load and reset mid-load.

module tb_td4_prog_loader;

    typedef logic [7:0] body_t [16];

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [4:0] exp_count;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset_n;
    logic       done;
    logic       error;
    logic [4:0] byte_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];
    logic [7:0] mem_model [16];

    body_t body_a;
    body_t body_b;
    body_t body_c;
    vec_t  vecs [16];

    td4_prog_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_reset_n (cpu_reset_n),
        .done        (done),
        .error       (error),
        .byte_count  (byte_count)
    );

    // 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Write monitor: logs every strobe and mirrors it into a memory model.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
            mem_model[mem_addr] = mem_wdata;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the edge.
    task automatic apply_stimulus(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Move past the falling edge so the write monitor has caught up.
    task automatic sync_log();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [7:0] checksum_of(input body_t b);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + b[i];
        return 8'h00 - s;
    endfunction

    task automatic send_frame(input body_t b, input logic [7:0] csum);
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, b[i]);
        apply_stimulus(1'b0, 1'b1, csum);
    endtask

    // Compare the n writes logged from position base against body b.
    task automatic check_writes(input string name, input int base, input body_t b);
        sync_log();
        check_output({name, " write count"}, wr_addr_log.size() - base, 16);
        if (wr_addr_log.size() >= base + 16) begin
            for (int i = 0; i < 16; i++) begin
                check_output({name, " addr"}, wr_addr_log[base + i], i);
                check_output({name, " data"}, wr_data_log[base + i], b[i]);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, " in_ready"}, in_ready, 0);
        check_output({name, " mem_we"}, mem_we, 0);
        check_output({name, " mem_addr"}, mem_addr, 0);
        check_output({name, " mem_wdata"}, mem_wdata, 0);
        check_output({name, " cpu_reset_n"}, cpu_reset_n, 0);
        check_output({name, " done"}, done, 0);
        check_output({name, " error"}, error, 0);
        check_output({name, " byte_count"}, byte_count, 0);
    endtask

    // No strobes and no ready while parked in a non-accepting state.
    task automatic check_blocked(input string name);
        int base;
        sync_log();
        base = wr_addr_log.size();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 8'hA5);
            check_output({name, " in_ready"}, in_ready, 0);
        end
        sync_log();
        check_output({name, " no writes"}, wr_addr_log.size() - base, 0);
    endtask

    initial begin
        int  base;
        int  sent;
        int  cycles;
        logic v;

        body_a = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                   8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        for (int i = 0; i < 16; i++) begin
            body_b[i] = 8'(i * 29 + 7);
            body_c[i] = 8'hC0 + 8'(i);
        end
        body_b[3] = 8'hA5;

        vecs[0]  = '{8'hB7, 4'd0,  8'hB7, 5'd1};
        vecs[1]  = '{8'h01, 4'd1,  8'h01, 5'd2};
        vecs[2]  = '{8'hE1, 4'd2,  8'hE1, 5'd3};
        vecs[3]  = '{8'h01, 4'd3,  8'h01, 5'd4};
        vecs[4]  = '{8'hE3, 4'd4,  8'hE3, 5'd5};
        vecs[5]  = '{8'hB6, 4'd5,  8'hB6, 5'd6};
        vecs[6]  = '{8'h01, 4'd6,  8'h01, 5'd7};
        vecs[7]  = '{8'hE6, 4'd7,  8'hE6, 5'd8};
        vecs[8]  = '{8'h01, 4'd8,  8'h01, 5'd9};
        vecs[9]  = '{8'hE8, 4'd9,  8'hE8, 5'd10};
        vecs[10] = '{8'hB0, 4'd10, 8'hB0, 5'd11};
        vecs[11] = '{8'hB4, 4'd11, 8'hB4, 5'd12};
        vecs[12] = '{8'h01, 4'd12, 8'h01, 5'd13};
        vecs[13] = '{8'hEA, 4'd13, 8'hEA, 5'd14};
        vecs[14] = '{8'hB8, 4'd14, 8'hB8, 5'd15};
        vecs[15] = '{8'hFF, 4'd15, 8'hFF, 5'd16};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        check_blocked("idle");

        // Good frame, table driven. Sum of the body is 0x09, checksum 0xF7.
        $display("[TB] good frame");
        sync_log();
        base = wr_addr_log.size();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("sync in_ready", in_ready, 1);
        check_output("sync cpu_reset_n", cpu_reset_n, 0);
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        check_output("header no write", mem_we, 0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b1, vecs[i].data);
            check_output("tbl mem_we", mem_we, 1);
            check_output("tbl mem_addr", mem_addr, vecs[i].exp_addr);
            check_output("tbl mem_wdata", mem_wdata, vecs[i].exp_wdata);
            check_output("tbl byte_count", byte_count, vecs[i].exp_count);
            check_output("tbl done", done, 0);
        end
        check_output("check in_ready", in_ready, 1);
        apply_stimulus(1'b0, 1'b1, 8'hF7);
        check_output("good done", done, 1);
        check_output("good error", error, 0);
        check_output("good cpu_reset_n", cpu_reset_n, 1);
        check_output("good byte_count", byte_count, 16);
        check_output("good mem_we after csum", mem_we, 0);
        check_writes("good", base, body_a);
        check_blocked("run");

        // Bad checksum, leaving RUN via start.
        $display("[TB] bad checksum");
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("run->sync done", done, 0);
        check_output("run->sync cpu_reset_n", cpu_reset_n, 0);
        send_frame(body_a, 8'hF8);
        check_output("bad error", error, 1);
        check_output("bad done", done, 0);
        check_output("bad cpu_reset_n", cpu_reset_n, 0);
        check_blocked("error");
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("error->sync error", error, 0);
        send_frame(body_a, checksum_of(body_a));
        check_output("recover done", done, 1);
        check_output("recover error", error, 0);

        // Resync: garbage before the header is dropped; A5 inside body is data.
        $display("[TB] resync");
        apply_stimulus(1'b1, 1'b0, 8'h00);
        sync_log();
        base = wr_addr_log.size();
        apply_stimulus(1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b0, 1'b1, 8'hFF);
        apply_stimulus(1'b0, 1'b1, 8'h5A);
        sync_log();
        check_output("resync no writes", wr_addr_log.size() - base, 0);
        check_output("resync byte_count", byte_count, 0);
        send_frame(body_b, checksum_of(body_b));
        check_output("resync done", done, 1);
        check_writes("resync", base, body_b);

        // Backpressure: random gaps in in_valid during LOAD.
        $display("[TB] backpressure");
        apply_stimulus(1'b1, 1'b0, 8'h00);
        sync_log();
        base = wr_addr_log.size();
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        sent   = 0;
        cycles = 0;
        while (sent < 16 && cycles < 400) begin
            v = 1'($urandom_range(0, 1));
            if (v && in_ready) begin
                apply_stimulus(1'b0, 1'b1, body_c[sent]);
                sent++;
            end else begin
                apply_stimulus(1'b0, 1'b0, 8'hEE);
            end
            cycles++;
        end
        check_output("bp bytes sent", sent, 16);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, checksum_of(body_c));
        check_output("bp done", done, 1);
        check_writes("bp", base, body_c);

        // Restart mid-load: start coincides with the 8th byte, which is dropped.
        $display("[TB] restart mid-load");
        apply_stimulus(1'b1, 1'b0, 8'h00);
        sync_log();
        base = wr_addr_log.size();
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b1, body_a[i]);
        check_output("restart pre count", byte_count, 7);
        apply_stimulus(1'b1, 1'b1, body_a[7]);
        check_output("restart mem_we", mem_we, 0);
        check_output("restart byte_count", byte_count, 0);
        check_output("restart in_ready", in_ready, 1);
        sync_log();
        check_output("restart writes so far", wr_addr_log.size() - base, 7);
        base = wr_addr_log.size();
        send_frame(body_b, checksum_of(body_b));
        check_output("restart done", done, 1);
        check_writes("restart", base, body_b);

        // Reset mid-load after 5 data bytes, with a 6th byte offered.
        $display("[TB] reset mid-load");
        apply_stimulus(1'b1, 1'b0, 8'h00);
        sync_log();
        base = wr_addr_log.size();
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, body_c[i] ^ 8'h3C);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = body_c[5];
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_values("midreset");
        check_blocked("after reset");
        sync_log();
        check_output("midreset writes", wr_addr_log.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            check_output("midreset kept", mem_model[i], body_c[i] ^ 8'h3C);
        end
        check_output("midreset old addr5", mem_model[5], body_b[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
